// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic ParEven  = 1'b0;
  localparam logic ParOdd   = 1'b1;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;
  localparam logic IdleLvl  = 1'b1;

  // Odd parity is the inverse of the plain XOR of the data bits.
  function automatic logic parity_bit(logic xor_acc, logic par_typ);
    return xor_acc ^ (par_typ == ParOdd);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_serializer.sv
// Data-phase shifter: shift register, bit counter, running XOR and last-bit flag.
module fifo_uart_tx_serializer #(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [DSIZE-1:0] data_i,
  output logic             bit_o,
  output logic             last_o,
  output logic             parity_o
);

  localparam int unsigned CntW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  logic [DSIZE-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             par_q, par_d;

  assign bit_o    = shift_q[0];
  assign last_o   = (cnt_q == CntW'(DSIZE - 1));
  assign parity_o = par_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
      par_d   = 1'b0;
    end else if (shift_i) begin
      shift_d = shift_q >> 1;
      cnt_d   = last_o ? '0 : cnt_q + CntW'(1);
      // Accumulates every bit as it leaves, so it is complete when the parity slot arrives.
      par_d   = par_q ^ shift_q[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from the async FIFO read port and frames them on TX_OUT.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             rinc,
  output logic             TX_OUT,
  output logic             busy
);

  tx_state_e state_q;
  logic      tx_q;
  logic      busy_q;
  logic      par_en_q;
  logic      par_typ_q;

  logic      pop;
  logic      ser_bit;
  logic      ser_last;
  logic      ser_par;

  // Pop only when free; gated by RST so a reset-held block never drains the FIFO.
  assign pop    = RST & ~rempty & ((state_q == StIdle) | (state_q == StStop));
  assign rinc   = pop;
  assign TX_OUT = tx_q;
  assign busy   = busy_q;

  fifo_uart_tx_serializer #(
    .DSIZE(DSIZE)
  ) u_serializer (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .load_i  (pop),
    .shift_i (state_q == StData),
    .data_i  (rdata),
    .bit_o   (ser_bit),
    .last_o  (ser_last),
    .parity_o(ser_par)
  );

  // Line level and busy are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      tx_q      <= IdleLvl;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= ParEven;
    end else begin
      busy_q <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          tx_q <= IdleLvl;
          if (pop) begin
            state_q   <= StStart;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end
        StStart: begin
          tx_q    <= StartBit;
          state_q <= StData;
        end
        StData: begin
          tx_q <= ser_bit;
          if (ser_last) begin
            state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          tx_q    <= parity_bit(ser_par, par_typ_q);
          state_q <= StStop;
        end
        StStop: begin
          tx_q <= StopBit;
          if (pop) begin
            state_q   <= StStart;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          tx_q    <= IdleLvl;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO feeds the DUT; a frame-level model predicts the line.
module tb_fifo_uart_tx;

  localparam int unsigned DSIZE = 8;
  localparam int          LogN  = 4096;

  logic             CLK     = 1'b0;
  logic             RST     = 1'b1;
  logic             rempty  = 1'b1;
  logic [DSIZE-1:0] rdata;
  logic             PAR_EN  = 1'b0;
  logic             PAR_TYP = 1'b0;
  logic             rinc;
  logic             TX_OUT;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] words_q[$];
  logic             pop_pend = 1'b0;

  logic tx_log   [LogN];
  logic busy_log [LogN];
  logic rinc_log [LogN];
  logic pen_log  [LogN];
  logic ptyp_log [LogN];
  logic exp_tx   [LogN];
  logic exp_busy [LogN];
  logic exp_rinc [LogN];

  fifo_uart_tx #(
    .DSIZE(DSIZE)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .rempty (rempty),
    .rdata  (rdata),
    .PAR_EN (PAR_EN),
    .PAR_TYP(PAR_TYP),
    .rinc   (rinc),
    .TX_OUT (TX_OUT),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  // FIFO read port: empty flag and head word are registered, updated the edge after a pop.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    rempty <= (fifo_q.size() == 0);
    rdata  <= (fifo_q.size() != 0) ? fifo_q[0] : 'x;
  end

  always @(negedge CLK) begin
    pop_pend <= rinc;
    if (cyc < LogN) begin
      tx_log[cyc]   <= TX_OUT;
      busy_log[cyc] <= busy;
      rinc_log[cyc] <= rinc;
      pen_log[cyc]  <= PAR_EN;
      ptyp_log[cyc] <= PAR_TYP;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic push_words();
    foreach (words_q[k]) fifo_q.push_back(words_q[k]);
  endtask

  task automatic wait_pop(input string name, output int p);
    p = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rinc_log[cyc] === 1'b1) begin
        p = cyc;
        break;
      end
    end
    checks++;
    if (p < 0) begin
      errors++;
      $display("FAIL %s pop timeout: no rinc within 60 cycles, required one", name);
    end
  endtask

  // Frame model: pops are DSIZE+2(+1 with parity) apart, line shows frame bit j at pop+2+j.
  function automatic void build_exp(int from, int to, int p);
    int               pc;
    int               len;
    int               idx;
    logic             b;
    logic [DSIZE-1:0] w;
    for (int c = from; c <= to; c++) begin
      exp_tx[c]   = 1'b1;
      exp_busy[c] = 1'b0;
      exp_rinc[c] = 1'b0;
    end
    pc = p;
    foreach (words_q[k]) begin
      w   = words_q[k];
      len = DSIZE + 2 + (pen_log[pc] ? 1 : 0);
      if (pc <= to) exp_rinc[pc] = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (j == 0) b = 1'b0;
        else if (j <= DSIZE) b = w[j-1];
        else if (j == DSIZE + 1 && len == DSIZE + 3) b = (^w) ^ ptyp_log[pc];
        else b = 1'b1;
        idx = pc + 2 + j;
        if (idx <= to) begin
          exp_tx[idx]   = b;
          exp_busy[idx] = 1'b1;
        end
      end
      pc += len;
    end
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({TX_OUT, busy, rinc} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold: tx/busy/rinc=%b required 100", {TX_OUT, busy, rinc});
      end
      tick();
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({TX_OUT, busy, rinc} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx/busy/rinc=%b required 100", i, {TX_OUT, busy, rinc});
      end
    end
  endtask

  task automatic test_single_frame();
    int p, to;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    words_q = {8'hA5};
    push_words();
    wait_pop("single", p);
    if (p < 0) return;
    to = p + (DSIZE + 3) + 4;
    while (cyc < to) tick();
    build_exp(p - 1, to, p);
    for (int c = p - 1; c <= to; c++) begin
      checks++;
      if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
        errors++;
        $display("FAIL single_a5 cycle %0d: tx/busy/rinc=%b required %b", c - p,
                 {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
      end
    end
  endtask

  task automatic test_parity();
    int p, to;
    for (int t = 0; t < 2; t++) begin
      PAR_EN  = 1'b1;
      PAR_TYP = t[0];
      words_q = {8'h03};
      push_words();
      wait_pop("parity", p);
      if (p < 0) return;
      to = p + (DSIZE + 3) + 4;
      while (cyc < to) tick();
      build_exp(p, to, p);
      for (int c = p; c <= to; c++) begin
        checks++;
        if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
          errors++;
          $display("FAIL parity_typ%0d cycle %0d: tx/busy/rinc=%b required %b", t, c - p,
                   {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p, to;
    PAR_EN  = 1'b0;
    words_q = {8'h0F, 8'hF0};
    push_words();
    wait_pop("b2b", p);
    if (p < 0) return;
    to = p + 2 * (DSIZE + 3) + 4;
    while (cyc < to) tick();
    build_exp(p, to, p);
    for (int c = p; c <= to; c++) begin
      checks++;
      if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx/busy/rinc=%b required %b", c - p,
                 {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
      end
    end
  endtask

  task automatic test_random_bursts();
    int p, to, n;
    for (int burst = 0; burst < 5; burst++) begin
      n       = $urandom_range(1, 4);
      PAR_EN  = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      words_q = {};
      for (int k = 0; k < n; k++) words_q.push_back(DSIZE'($urandom));
      push_words();
      wait_pop("random", p);
      if (p < 0) return;
      to = p + n * (DSIZE + 3) + 4;
      while (cyc < to) tick();
      build_exp(p, to, p);
      for (int c = p; c <= to; c++) begin
        checks++;
        if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
          errors++;
          $display("FAIL random_burst%0d cycle %0d: tx/busy/rinc=%b required %b", burst, c - p,
                   {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int p, p2, rc, to;
    PAR_EN  = 1'b0;
    words_q = {8'hFF};
    push_words();
    wait_pop("reset_mid", p);
    if (p < 0) return;
    while (cyc < p + 6) tick();
    checks++;
    if ({TX_OUT, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_d3: tx/busy=%b required 11", {TX_OUT, busy});
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_async: tx/busy=%b required 10", {TX_OUT, busy});
    end
    fifo_q.push_back(8'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({TX_OUT, busy, rinc} !== 3'b100) begin
        errors++;
        $display("FAIL reset_mid_hold: tx/busy/rinc=%b required 100", {TX_OUT, busy, rinc});
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    rc  = cyc;
    wait_pop("reset_mid_resume", p2);
    if (p2 < 0) return;
    checks++;
    if (p2 !== rc) begin
      errors++;
      $display("FAIL reset_mid_pop_time: pop at cycle %0d required %0d", p2, rc);
    end
    words_q = {8'h5A};
    to = p2 + 2 * (DSIZE + 3) + 4;
    while (cyc < to) tick();
    build_exp(p2, to, p2);
    for (int c = p2; c <= to; c++) begin
      checks++;
      if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
        errors++;
        $display("FAIL reset_mid_next cycle %0d: tx/busy/rinc=%b required %b", c - p2,
                 {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
      end
    end
    checks++;
    if (fifo_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_fifo: %0d words left required 0", fifo_q.size());
    end
  endtask

  task automatic test_par_toggle();
    int p, to;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    words_q = {DSIZE'($urandom), DSIZE'($urandom)};
    push_words();
    wait_pop("par_toggle", p);
    if (p < 0) return;
    while (cyc < p + 4) tick();
    PAR_EN  = 1'b1;
    PAR_TYP = 1'($urandom_range(0, 1));
    to = p + 2 * (DSIZE + 3) + 4;
    while (cyc < to) tick();
    build_exp(p, to, p);
    for (int c = p; c <= to; c++) begin
      checks++;
      if ({tx_log[c], busy_log[c], rinc_log[c]} !== {exp_tx[c], exp_busy[c], exp_rinc[c]}) begin
        errors++;
        $display("FAIL par_toggle cycle %0d: tx/busy/rinc=%b required %b", c - p,
                 {tx_log[c], busy_log[c], rinc_log[c]}, {exp_tx[c], exp_busy[c], exp_rinc[c]});
      end
    end
    PAR_EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_random_bursts();
    test_reset_mid_frame();
    test_par_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
